quad_encoder_channel: RTL and testbench
=======================================

Name: quad_encoder_channel

Overview:
Parametrised, fully synchronous successor to the team's edge-triggered incremental encoder. It synchronises and glitch-filters raw A/B/I encoder lines and decodes quadrature in x1, x2 or x4 mode into a WIDTH-bit signed position. It supports CPR wrap, selectable index behaviour, illegal-transition detection and bus-loaded CPR/position registers. One instance serves one axis; the motion controller instantiates one per encoder and reads it over the shared data bus.

Parameters:
WIDTH, 32, width of position, CPR, load bus and index-latch registers
CNT_WIDTH, 16, width of the index pulse counter
FILTER_DEPTH, 4, consecutive stable clocks required before a synchronised input is accepted (legal range 1..255)

Ports:
clk  in  1  system clock; all state changes on its rising edge
Reset  in  1  reset, asynchronous, active-high
a_in, b_in, i_in  in  1 each  raw encoder lines, asynchronous to clk
load_data  in  WIDTH  value for set_cpr / set_position
set_cpr  in  1  one-clock strobe: CPR <= load_data
set_position  in  1  one-clock strobe: position <= load_data
cpr_en  in  1  enables modulo-CPR wrap
decode_mode  in  2  0 = x1, 1 = x2, 2/3 = x4
index_mode  in  2  0 = ignore, 1 = count, 2 = zero on CW index, 3 = latch
clear_error  in  1  one-clock strobe that clears error
position  out  WIDTH  signed position
index_position  out  WIDTH  position captured at last index (mode 3)
index_count  out  CNT_WIDTH  index pulses seen, wraps modulo 2^CNT_WIDTH
direction  out  1  1 = CW, 0 = CCW; last counted step
step  out  1  one-clock pulse on every counted step
error  out  1  sticky illegal-transition flag

Behaviour:
- Reset (async): position, index_position, CPR, index_count, direction, step, error, and all sync/filter registers go to 0; primed = 0.
- Synchroniser: 2 flops per line.
- Filter: per-line counter of clocks where the synced value differs from the filtered value. The filtered value updates when the difference has persisted FILTER_DEPTH clocks; any agreement clears the counter.
- Latency: a_in/b_in edge to position/step change is exactly FILTER_DEPTH+3 clocks. Pulses shorter than FILTER_DEPTH clocks are never counted.
- Priming: the first clock after Reset deasserts, prev_AB <= filtered AB with no count and no error; primed <= 1.
- State (A,B) CW sequence: 00 -> 01 -> 11 -> 10 -> 00. The reverse sequence is CCW.
- x4: every legal transition counts.
- x2: only transitions that change A count.
- x1: only 01 -> 11 (CW) and 11 -> 01 (CCW) count.
- Both bits changing in one filtered sample: no count; error <= 1.
- error is sticky until clear_error. If clear_error and a new illegal transition occur in the same clock, error stays 1.
- Counted CW step:
  - if cpr_en and CPR != 0 and position == CPR-1, position <= 0;
  - otherwise position + 1, two's-complement wrap at WIDTH.
- Counted CCW step:
  - if cpr_en and CPR != 0 and position == 0, position <= CPR-1;
  - otherwise position - 1.
- cpr_en with CPR == 0 behaves as cpr_en = 0.
- Any counted step: direction updates and step pulses high for 1 clock.
- Index event: rising edge of filtered I.
  - Modes 1-3: index_count + 1.
  - Mode 2: position <= 0 only if direction == CW.
  - Mode 3: index_position <= position value before any same-clock update.
  - Mode 0: nothing.
- Same-clock priority for position: set_position > mode-2 index zero > step.
  - step, direction and index_count still update when lower-priority position writes are overridden.
- set_cpr and set_position in the same clock both load load_data.
- set_position with cpr_en is not range-checked. Wrap compares for equality only, so an out-of-range value counts freely until it hits a compare value.
- decode_mode, index_mode and cpr_en may change at any time and take effect on the next clock.

Test Plan:
1. FILTER_DEPTH=4, x4, 10 full CW cycles (AB 00, 01, 11, 10, each held 8 clocks) -> position = 40, direction = 1, 40 step pulses; first step 7 clocks after the first a_in/b_in change.
2. x1 and x2 each: 3 CW cycles then 3 CCW cycles -> x1 peaks at 3 and returns to 0; x2 peaks at 6 and returns to 0.
3. set_cpr 100, cpr_en = 1, set_position 99, one CW step -> 0; one CCW step -> 99; cpr_en = 0 at position 0, CCW step -> 0xFFFFFFFF.
4. 3-clock glitch on a_in -> no step; AB 00 -> 11 held 8 clocks -> error = 1, position unchanged; clear_error -> error = 0.
5. index_mode 2, position 57, direction CW, I pulse -> position 0, index_count 1. Repeat moving CCW -> position unchanged, index_count 2. Mode 3 -> index_position = current position.
6. Reset asserted mid-motion with AB = 11 at release -> all outputs 0, no error, no step on the priming clock; set_position with a coincident step -> load_data wins.

Source files
------------

// File: rtl/quad_encoder_channel.sv
// Single-axis quadrature decoder: synchronises and filters A/B/I, then decodes x1/x2/x4
// into a signed position with optional CPR wrap, index handling and illegal-step detection.
module quad_encoder_channel #(
  parameter int WIDTH        = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int FILTER_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 i_in,
  input  logic [WIDTH-1:0]     load_data,
  input  logic                 set_cpr,
  input  logic                 set_position,
  input  logic                 cpr_en,
  input  logic [1:0]           decode_mode,
  input  logic [1:0]           index_mode,
  input  logic                 clear_error,
  output logic [WIDTH-1:0]     position,
  output logic [WIDTH-1:0]     index_position,
  output logic [CNT_WIDTH-1:0] index_count,
  output logic                 direction,
  output logic                 step,
  output logic                 error
);

  localparam logic [7:0] FILT_LAST = 8'(FILTER_DEPTH - 1);

  logic [2:0] raw_in;
  logic [2:0] filt;

  assign raw_in = {i_in, b_in, a_in};

  // Lines 0/1/2 = A/B/I: two-flop synchroniser followed by a persistence filter.
  for (genvar gi = 0; gi < 3; gi++) begin : g_line
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q, filt_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d = raw_in[gi];
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = 8'd0;
      if (sync2_q != filt_q) begin
        if (cnt_q == FILT_LAST) filt_d = sync2_q;
        else                    cnt_d  = cnt_q + 8'd1;
      end
    end

    always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        filt_q  <= 1'b0;
        cnt_q   <= 8'd0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        filt_q  <= filt_d;
        cnt_q   <= cnt_d;
      end
    end

    assign filt[gi] = filt_q;
  end

  // Gray-sequence phase of an (A,B) pair: 00 -> 01 -> 11 -> 10 is CW.
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    case (ab)
      2'b00:   phase_of = 2'd0;
      2'b01:   phase_of = 2'd1;
      2'b11:   phase_of = 2'd2;
      default: phase_of = 2'd3;
    endcase
  endfunction

  logic [1:0]           prev_ab_q, prev_ab_d;
  logic                 primed_q, primed_d;
  logic                 index_prev_q, index_prev_d;
  logic [WIDTH-1:0]     position_q, position_d;
  logic [WIDTH-1:0]     index_position_q, index_position_d;
  logic [WIDTH-1:0]     cpr_q, cpr_d;
  logic [CNT_WIDTH-1:0] index_count_q, index_count_d;
  logic                 direction_q, direction_d;
  logic                 step_q, step_d;
  logic                 error_q, error_d;

  logic [1:0] ab_cur;
  logic       a_chg, b_chg, fwd, rev, illegal;
  logic       qual_cw, qual_ccw, count_cw, count_ccw;
  logic       cpr_active, index_evt;

  assign ab_cur = {filt[0], filt[1]};

  always_comb begin
    prev_ab_d        = ab_cur;
    primed_d         = 1'b1;
    index_prev_d     = filt[2];
    position_d       = position_q;
    index_position_d = index_position_q;
    cpr_d            = cpr_q;
    index_count_d    = index_count_q;
    direction_d      = direction_q;
    step_d           = 1'b0;
    error_d          = error_q;

    a_chg   = prev_ab_q[1] ^ ab_cur[1];
    b_chg   = prev_ab_q[0] ^ ab_cur[0];
    fwd     = (phase_of(ab_cur) == phase_of(prev_ab_q) + 2'd1);
    rev     = (phase_of(ab_cur) == phase_of(prev_ab_q) - 2'd1);
    illegal = primed_q & a_chg & b_chg;

    case (decode_mode)
      2'd0: begin
        qual_cw  = (prev_ab_q == 2'b01) && (ab_cur == 2'b11);
        qual_ccw = (prev_ab_q == 2'b11) && (ab_cur == 2'b01);
      end
      2'd1: begin
        qual_cw  = a_chg;
        qual_ccw = a_chg;
      end
      default: begin
        qual_cw  = 1'b1;
        qual_ccw = 1'b1;
      end
    endcase

    count_cw   = primed_q & fwd & qual_cw;
    count_ccw  = primed_q & rev & qual_ccw;
    cpr_active = cpr_en && (cpr_q != '0);
    index_evt  = filt[2] & ~index_prev_q;

    if (count_cw) begin
      direction_d = 1'b1;
      step_d      = 1'b1;
      position_d  = (cpr_active && position_q == cpr_q - WIDTH'(1)) ? '0 : position_q + WIDTH'(1);
    end else if (count_ccw) begin
      direction_d = 1'b0;
      step_d      = 1'b1;
      position_d  = (cpr_active && position_q == '0) ? cpr_q - WIDTH'(1) : position_q - WIDTH'(1);
    end

    if (index_evt && index_mode != 2'd0) index_count_d = index_count_q + CNT_WIDTH'(1);
    if (index_evt && index_mode == 2'd3) index_position_d = position_q;
    if (index_evt && index_mode == 2'd2 && direction_q) position_d = '0;

    // Bus writes override any decoder-driven position change in the same clock.
    if (set_position) position_d = load_data;
    if (set_cpr)      cpr_d      = load_data;

    if (illegal)          error_d = 1'b1;
    else if (clear_error) error_d = 1'b0;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      prev_ab_q        <= 2'b00;
      primed_q         <= 1'b0;
      index_prev_q     <= 1'b0;
      position_q       <= '0;
      index_position_q <= '0;
      cpr_q            <= '0;
      index_count_q    <= '0;
      direction_q      <= 1'b0;
      step_q           <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      prev_ab_q        <= prev_ab_d;
      primed_q         <= primed_d;
      index_prev_q     <= index_prev_d;
      position_q       <= position_d;
      index_position_q <= index_position_d;
      cpr_q            <= cpr_d;
      index_count_q    <= index_count_d;
      direction_q      <= direction_d;
      step_q           <= step_d;
      error_q          <= error_d;
    end
  end

  assign position       = position_q;
  assign index_position = index_position_q;
  assign index_count    = index_count_q;
  assign direction      = direction_q;
  assign step           = step_q;
  assign error          = error_q;

endmodule

// File: tb/tb_quad_encoder_channel.sv
// Directed bench for quad_encoder_channel with hand-computed expectations per scenario.
module tb_quad_encoder_channel;

  logic        clk = 1'b0;
  logic        Reset;
  logic        a_in, b_in, i_in;
  logic [31:0] load_data;
  logic        set_cpr, set_position, cpr_en;
  logic [1:0]  decode_mode, index_mode;
  logic        clear_error;
  logic [31:0] position, index_position;
  logic [15:0] index_count;
  logic        direction, step, error;

  int n_cmp = 0;
  int n_bad = 0;
  int step_seen = 0;
  logic cur_a = 1'b0;
  logic cur_b = 1'b0;

  quad_encoder_channel #(.WIDTH(32), .CNT_WIDTH(16), .FILTER_DEPTH(4)) dut (
    .clk(clk), .Reset(Reset), .a_in(a_in), .b_in(b_in), .i_in(i_in),
    .load_data(load_data), .set_cpr(set_cpr), .set_position(set_position),
    .cpr_en(cpr_en), .decode_mode(decode_mode), .index_mode(index_mode),
    .clear_error(clear_error), .position(position), .index_position(index_position),
    .index_count(index_count), .direction(direction), .step(step), .error(error)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (step === 1'b1) step_seen++;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set_ab(input logic a, input logic b);
    cur_a = a; cur_b = b;
    a_in = a;  b_in = b;
  endtask

  task automatic cw_step();
    case ({cur_a, cur_b})
      2'b00:   set_ab(1'b0, 1'b1);
      2'b01:   set_ab(1'b1, 1'b1);
      2'b11:   set_ab(1'b1, 1'b0);
      default: set_ab(1'b0, 1'b0);
    endcase
    hold(8);
  endtask

  task automatic ccw_step();
    case ({cur_a, cur_b})
      2'b00:   set_ab(1'b1, 1'b0);
      2'b10:   set_ab(1'b1, 1'b1);
      2'b11:   set_ab(1'b0, 1'b1);
      default: set_ab(1'b0, 1'b0);
    endcase
    hold(8);
  endtask

  task automatic load_pos(input logic [31:0] v);
    load_data = v; set_position = 1'b1;
    tick();
    set_position = 1'b0; load_data = '0;
  endtask

  task automatic pulse_index();
    i_in = 1'b1; hold(6);
    i_in = 1'b0; hold(8);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    hold(3);
    n_cmp++; if (position !== 32'd0) begin n_bad++; $display("FAIL reset_position: got %0h expected 0", position); end
    n_cmp++; if ({step, error, direction} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {step, error, direction}); end
    n_cmp++; if (index_count !== 16'd0) begin n_bad++; $display("FAIL reset_index_count: got %0d expected 0", index_count); end
    Reset = 1'b0;
    hold(8);
    $display("test_reset done");
  endtask

  task automatic test_x4_cw();
    decode_mode = 2'd2;
    step_seen = 0;
    set_ab(1'b0, 1'b1);
    hold(6);
    n_cmp++; if (step_seen !== 0 || position !== 32'd0) begin n_bad++; $display("FAIL latency_early: got steps %0d pos %0d expected 0 0", step_seen, position); end
    tick();
    n_cmp++; if (step !== 1'b1 || position !== 32'd1) begin n_bad++; $display("FAIL latency_7clk: got step %b pos %0d expected 1 1", step, position); end
    hold(1);
    repeat (39) cw_step();
    n_cmp++; if (position !== 32'd40) begin n_bad++; $display("FAIL x4_position: got %0d expected 40", position); end
    n_cmp++; if (direction !== 1'b1) begin n_bad++; $display("FAIL x4_direction: got %b expected 1", direction); end
    n_cmp++; if (step_seen !== 40) begin n_bad++; $display("FAIL x4_step_count: got %0d expected 40", step_seen); end
    $display("test_x4_cw position=%0d steps=%0d", position, step_seen);
  endtask

  task automatic test_x1_x2();
    load_pos(32'd0);
    decode_mode = 2'd0;
    repeat (12) cw_step();
    n_cmp++; if (position !== 32'd3) begin n_bad++; $display("FAIL x1_peak: got %0d expected 3", position); end
    repeat (12) ccw_step();
    n_cmp++; if (position !== 32'd0 || direction !== 1'b0) begin n_bad++; $display("FAIL x1_return: got pos %0d dir %b expected 0 0", position, direction); end
    decode_mode = 2'd1;
    repeat (12) cw_step();
    n_cmp++; if (position !== 32'd6) begin n_bad++; $display("FAIL x2_peak: got %0d expected 6", position); end
    repeat (12) ccw_step();
    n_cmp++; if (position !== 32'd0) begin n_bad++; $display("FAIL x2_return: got %0d expected 0", position); end
    $display("test_x1_x2 done");
  endtask

  task automatic test_cpr_wrap();
    decode_mode = 2'd3;
    load_data = 32'd100; set_cpr = 1'b1;
    tick();
    set_cpr = 1'b0;
    cpr_en = 1'b1;
    load_pos(32'd99);
    cw_step();
    n_cmp++; if (position !== 32'd0 || direction !== 1'b1) begin n_bad++; $display("FAIL cpr_wrap_up: got pos %0d dir %b expected 0 1", position, direction); end
    ccw_step();
    n_cmp++; if (position !== 32'd99 || direction !== 1'b0) begin n_bad++; $display("FAIL cpr_wrap_down: got pos %0d dir %b expected 99 0", position, direction); end
    load_pos(32'd0);
    cpr_en = 1'b0;
    ccw_step();
    n_cmp++; if (position !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL nocpr_underflow: got %0h expected ffffffff", position); end
    $display("test_cpr_wrap done");
  endtask

  task automatic test_glitch_error();
    int steps0;
    steps0 = step_seen;
    a_in = ~cur_a; hold(3);
    a_in = cur_a;  hold(10);
    n_cmp++; if (step_seen !== steps0 || position !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL glitch_rejected: got steps %0d pos %0h expected %0d ffffffff", step_seen, position, steps0); end
    cw_step();
    n_cmp++; if (position !== 32'd0) begin n_bad++; $display("FAIL step_after_glitch: got %0h expected 0", position); end
    steps0 = step_seen;
    set_ab(1'b1, 1'b1);
    hold(8);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL illegal_error: got %b expected 1", error); end
    n_cmp++; if (position !== 32'd0 || step_seen !== steps0) begin n_bad++; $display("FAIL illegal_no_count: got pos %0h steps %0d expected 0 %0d", position, step_seen, steps0); end
    clear_error = 1'b1; tick(); clear_error = 1'b0;
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL clear_error: got %b expected 0", error); end
    $display("test_glitch_error done");
  endtask

  task automatic test_index();
    load_pos(32'd56);
    cw_step();
    n_cmp++; if (position !== 32'd57 || direction !== 1'b1) begin n_bad++; $display("FAIL index_setup_cw: got pos %0d dir %b expected 57 1", position, direction); end
    index_mode = 2'd2;
    pulse_index();
    n_cmp++; if (position !== 32'd0 || index_count !== 16'd1) begin n_bad++; $display("FAIL index_zero_cw: got pos %0d cnt %0d expected 0 1", position, index_count); end
    load_pos(32'd20);
    ccw_step();
    pulse_index();
    n_cmp++; if (position !== 32'd19 || index_count !== 16'd2) begin n_bad++; $display("FAIL index_ccw_keep: got pos %0d cnt %0d expected 19 2", position, index_count); end
    index_mode = 2'd3;
    pulse_index();
    n_cmp++; if (index_position !== 32'd19 || index_count !== 16'd3) begin n_bad++; $display("FAIL index_latch: got ipos %0d cnt %0d expected 19 3", index_position, index_count); end
    index_mode = 2'd0;
    pulse_index();
    n_cmp++; if (index_count !== 16'd3 || position !== 32'd19) begin n_bad++; $display("FAIL index_ignore: got cnt %0d pos %0d expected 3 19", index_count, position); end
    $display("test_index done");
  endtask

  task automatic test_reset_priming();
    set_ab(1'b0, 1'b1);
    hold(3);
    Reset = 1'b1;
    #1;
    n_cmp++; if (position !== 32'd0 || index_count !== 16'd0) begin n_bad++; $display("FAIL async_reset: got pos %0h cnt %0d expected 0 0", position, index_count); end
    set_ab(1'b1, 1'b1);
    hold(3);
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (step !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL priming_quiet clk%0d: got step %b err %b expected 0 0", k, step, error); end
    end
    n_cmp++; if (position !== 32'd0 || direction !== 1'b0 || index_position !== 32'd0) begin n_bad++; $display("FAIL post_reset_state: got pos %0h dir %b ipos %0h expected 0 0 0", position, direction, index_position); end
    hold(4);
    clear_error = 1'b1; tick(); clear_error = 1'b0;
    set_ab(1'b1, 1'b0);
    hold(6);
    load_data = 32'd1234; set_position = 1'b1;
    tick();
    set_position = 1'b0; load_data = '0;
    n_cmp++; if (position !== 32'd1234) begin n_bad++; $display("FAIL set_pos_priority: got %0d expected 1234", position); end
    n_cmp++; if (step !== 1'b1 || direction !== 1'b1) begin n_bad++; $display("FAIL set_pos_step_kept: got step %b dir %b expected 1 1", step, direction); end
    $display("test_reset_priming done");
  endtask

  initial begin
    Reset = 1'b1;
    a_in = 1'b0; b_in = 1'b0; i_in = 1'b0;
    load_data = '0; set_cpr = 1'b0; set_position = 1'b0; cpr_en = 1'b0;
    decode_mode = 2'd2; index_mode = 2'd0; clear_error = 1'b0;
    test_reset();
    test_x4_cw();
    test_x1_x2();
    test_cpr_wrap();
    test_glitch_error();
    test_index();
    test_reset_priming();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
